// File: rtl/shift_reg_seq.sv
// shift_reg_seq
// WIDTH-bit universal shift register with a multi-step shift/rotate sequencer.
// In IDLE it performs one step of `mode` per enabled clock (en=1). A `start`
// request runs the selected shift/rotate for `amt` consecutive clocks. While
// the sequence runs, busy is high. A one-cycle done pulse marks completion.
//
// Ports
//   clk     in   clock, all state updates on the rising edge
//   reset   in   synchronous active-high reset
//   en      in   single-step enable (IDLE only)
//   mode    in   3-bit operation select:
//                  000 hold, 001 SHL, 010 SHR, 011 ROL,
//                  100 ROR, 101 LOAD, 110 ASR, 111 CLEAR
//   d       in   parallel load data
//   sin_l   in   serial input entering bit 0 on SHL
//   sin_r   in   serial input entering bit WIDTH-1 on SHR
//   start   in   begin a multi-step operation (IDLE only)
//   amt     in   step count for start
//   q       out  register contents
//   qbar    out  ~q
//   sout_l  out  q[WIDTH-1]
//   sout_r  out  q[0]
//   busy    out  sequencer in RUN
//   done    out  one-cycle completion pulse for a start request
module shift_reg_seq #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_SHL   = 3'b001;
    localparam logic [2:0] M_SHR   = 3'b010;
    localparam logic [2:0] M_ROL   = 3'b011;
    localparam logic [2:0] M_ROR   = 3'b100;
    localparam logic [2:0] M_LOAD  = 3'b101;
    localparam logic [2:0] M_ASR   = 3'b110;
    localparam logic [2:0] M_CLEAR = 3'b111;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_r, state_nxt;
    logic [WIDTH-1:0] q_r, q_nxt;
    logic [2:0]       mode_r, mode_nxt;
    logic [AMT_W-1:0] rem_r, rem_nxt;
    logic             done_r, done_nxt;

    // One step of the selected operation applied to the current contents.
    function automatic logic [WIDTH-1:0] step_fn(
        input logic [WIDTH-1:0] cur,
        input logic [2:0]       op,
        input logic [WIDTH-1:0] ld,
        input logic             sl,
        input logic             sr
    );
        logic [WIDTH-1:0] r;
        case (op)
            M_SHL:   r = {cur[WIDTH-2:0], sl};
            M_SHR:   r = {sr, cur[WIDTH-1:1]};
            M_ROL:   r = {cur[WIDTH-2:0], cur[WIDTH-1]};
            M_ROR:   r = {cur[0], cur[WIDTH-1:1]};
            M_LOAD:  r = ld;
            M_ASR:   r = {cur[WIDTH-1], cur[WIDTH-1:1]};
            M_CLEAR: r = '0;
            default: r = cur;
        endcase
        return r;
    endfunction

    // Only shifts and rotates are meaningful to repeat. Hold, load and clear
    // collapse to a single operation whatever the count.
    function automatic logic is_multi(input logic [2:0] op);
        return (op == M_SHL) || (op == M_SHR) || (op == M_ROL) ||
               (op == M_ROR) || (op == M_ASR);
    endfunction

    always_comb begin
        state_nxt = state_r;
        q_nxt     = q_r;
        mode_nxt  = mode_r;
        rem_nxt   = rem_r;
        done_nxt  = 1'b0;
        case (state_r)
            RUN: begin
                // The latched mode is used here. Live en/mode/d/start/amt are ignored.
                q_nxt = step_fn(q_r, mode_r, '0, sin_l, sin_r);
                if (rem_r <= AMT_W'(1)) begin
                    state_nxt = IDLE;
                    rem_nxt   = '0;
                    done_nxt  = 1'b1;
                end else begin
                    rem_nxt = rem_r - AMT_W'(1);
                end
            end
            default: begin
                if (start) begin
                    if (is_multi(mode)) begin
                        // First step happens on the accepting edge. amt=0 leaves q alone.
                        if (amt != '0) begin
                            q_nxt = step_fn(q_r, mode, d, sin_l, sin_r);
                        end
                        if (amt >= AMT_W'(2)) begin
                            state_nxt = RUN;
                            mode_nxt  = mode;
                            rem_nxt   = amt - AMT_W'(1);
                        end else begin
                            done_nxt = 1'b1;
                        end
                    end else begin
                        q_nxt    = step_fn(q_r, mode, d, sin_l, sin_r);
                        done_nxt = 1'b1;
                    end
                end else if (en) begin
                    q_nxt = step_fn(q_r, mode, d, sin_l, sin_r);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            q_r     <= '0;
            mode_r  <= M_HOLD;
            rem_r   <= '0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt;
            q_r     <= q_nxt;
            mode_r  <= mode_nxt;
            rem_r   <= rem_nxt;
            done_r  <= done_nxt;
        end
    end

    assign q      = q_r;
    assign qbar   = ~q_r;
    assign sout_l = q_r[WIDTH-1];
    assign sout_r = q_r[0];
    assign busy   = (state_r == RUN);
    assign done   = done_r;

endmodule

// File: tb/tb_shift_reg_seq.sv
module tb_shift_reg_seq;

    localparam int WIDTH = 8;
    localparam int AMT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             en = 1'b0;
    logic [2:0]       mode = 3'd0;
    logic [WIDTH-1:0] d = '0;
    logic             sin_l = 1'b0;
    logic             sin_r = 1'b0;
    logic             start = 1'b0;
    logic [AMT_W-1:0] amt = '0;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic             sout_l;
    logic             sout_r;
    logic             busy;
    logic             done;

    logic [19:0] obs;
    assign obs = {q, qbar, sout_l, sout_r, busy, done};

    int n_checks = 0;
    int n_errors = 0;
    int mq = 0;

    shift_reg_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d),
        .sin_l(sin_l), .sin_r(sin_r), .start(start), .amt(amt),
        .q(q), .qbar(qbar), .sout_l(sout_l), .sout_r(sout_r),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference step: the register value is treated as an integer 0..255.
    function automatic int ref_step(input int cur, input int op, input int ld, input int sl, input int sr);
        case (op)
            1: return (cur * 2 + sl) % 256;
            2: return cur / 2 + sr * 128;
            3: return (cur * 2) % 256 + cur / 128;
            4: return cur / 2 + (cur % 2) * 128;
            5: return ld % 256;
            6: return cur / 2 + ((cur >= 128) ? 128 : 0);
            7: return 0;
            default: return cur;
        endcase
    endfunction

    // Expected observation vector built from the model value and status flags.
    function automatic logic [19:0] mk(input int eq, input logic eb, input logic ed);
        logic [7:0] v;
        v = eq[7:0];
        return {v, ~v, v[7], v[0], eb, ed};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int val);
        start = 1'b0; en = 1'b1; mode = 3'd5; d = val[7:0];
        tick();
        en = 1'b0;
        mq = val;
    endtask

    // Issues a start request and follows it to its done cycle, scoring every cycle.
    // Inputs that RUN must ignore are scrambled while the sequence runs.
    task automatic run_start(input int m, input int n, input string tag);
        logic is_sh, runs;
        int steps;
        is_sh = (m == 1) || (m == 2) || (m == 3) || (m == 4) || (m == 6);
        steps = is_sh ? n : 1;
        runs  = is_sh && (n >= 2);
        start = 1'b1; en = 1'($urandom); mode = m[2:0]; amt = n[AMT_W-1:0];
        d = 8'($urandom); sin_l = 1'($urandom); sin_r = 1'($urandom);
        tick();
        if (steps > 0) mq = ref_step(mq, m, int'(d), int'(sin_l), int'(sin_r));
        n_checks++;
        if (obs !== mk(mq, runs, !runs)) begin
            n_errors++;
            $display("FAIL %s_e0 got %h want %h", tag, obs, mk(mq, runs, !runs));
        end
        if (runs) begin
            for (int k = 1; k < n; k++) begin
                start = 1'($urandom); en = 1'($urandom); mode = 3'($urandom);
                d = 8'($urandom); amt = 4'($urandom);
                sin_l = 1'($urandom); sin_r = 1'($urandom);
                tick();
                mq = ref_step(mq, m, 0, int'(sin_l), int'(sin_r));
                n_checks++;
                if (obs !== mk(mq, k < n - 1, k == n - 1)) begin
                    n_errors++;
                    $display("FAIL %s_e%0d got %h want %h", tag, k, obs, mk(mq, k < n - 1, k == n - 1));
                end
            end
        end
        start = 1'b0; en = 1'b0;
    endtask

    task automatic idle_check(input string tag);
        start = 1'b0; en = 1'b0;
        tick();
        n_checks++;
        if (obs !== mk(mq, 1'b0, 1'b0)) begin
            n_errors++;
            $display("FAIL %s got %h want %h", tag, obs, mk(mq, 1'b0, 1'b0));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        do_load(8'hA5);
        n_checks++;
        if (q !== 8'hA5) begin
            n_errors++;
            $display("FAIL reset_preload got %h want a5", q);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (obs !== mk(0, 1'b0, 1'b0)) begin
            n_errors++;
            $display("FAIL reset_values got %h want %h", obs, mk(0, 1'b0, 1'b0));
        end
        en = 1'b1; mode = 3'd5; d = 8'h5A;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (obs !== mk(0, 1'b0, 1'b0)) begin
                n_errors++;
                $display("FAIL reset_hold got %h want %h", obs, mk(0, 1'b0, 1'b0));
            end
        end
        reset = 1'b0; en = 1'b0;
        mq = 0;
    endtask

    task automatic test_single_ops();
        int t_mode [8] = '{5, 1, 4, 6, 2, 7, 5, 1};
        int t_d    [8] = '{8'h81, 0, 0, 0, 0, 0, 8'h3C, 0};
        int t_sl   [8] = '{0, 1, 0, 0, 0, 0, 0, 1};
        int t_sr   [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        int t_en   [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
        int t_exp  [8] = '{8'h81, 8'h03, 8'h81, 8'hC0, 8'h60, 8'h00, 8'h3C, 8'h3C};
        for (int i = 0; i < 8; i++) begin
            start = 1'b0; en = 1'(t_en[i]); mode = 3'(t_mode[i]); d = 8'(t_d[i]);
            sin_l = 1'(t_sl[i]); sin_r = 1'(t_sr[i]);
            tick();
            n_checks++;
            if (obs !== mk(t_exp[i], 1'b0, 1'b0)) begin
                n_errors++;
                $display("FAIL single_op%0d got %h want %h", i, obs, mk(t_exp[i], 1'b0, 1'b0));
            end
        end
        mq = 8'h3C;
        for (int i = 0; i < 40; i++) begin
            start = 1'b0; en = 1'($urandom); mode = 3'($urandom); d = 8'($urandom);
            sin_l = 1'($urandom); sin_r = 1'($urandom); amt = 4'($urandom);
            tick();
            if (en) mq = ref_step(mq, int'(mode), int'(d), int'(sin_l), int'(sin_r));
            n_checks++;
            if (obs !== mk(mq, 1'b0, 1'b0)) begin
                n_errors++;
                $display("FAIL single_rand%0d got %h want %h", i, obs, mk(mq, 1'b0, 1'b0));
            end
        end
        en = 1'b0;
    endtask

    task automatic test_multi_step();
        do_load(8'h01);
        run_start(3, 3, "rol3");
        n_checks++;
        if (q !== 8'h08) begin
            n_errors++;
            $display("FAIL rol3_final got %h want 08", q);
        end
        idle_check("rol3_after");
    endtask

    task automatic test_edge_counts();
        do_load(8'h96);
        run_start(3, 0, "amt0");
        idle_check("amt0_after");
        run_start(2, 1, "amt1_shr");
        idle_check("amt1_after");
        do_load(8'h01);
        run_start(3, 9, "rol9");
        n_checks++;
        if (q !== 8'h02) begin
            n_errors++;
            $display("FAIL rol9_final got %h want 02", q);
        end
        idle_check("rol9_after");
        do_load(8'h5A);
        run_start(5, 0, "load_amt0");
        idle_check("load_amt0_after");
    endtask

    task automatic test_abort();
        logic [7:0] exp_q [3] = '{8'hFE, 8'hFC, 8'hF8};
        do_load(8'hFF);
        start = 1'b1; mode = 3'd1; amt = 4'd6; sin_l = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            start = 1'b0;
            n_checks++;
            if (obs !== mk(int'(exp_q[i]), 1'b1, 1'b0)) begin
                n_errors++;
                $display("FAIL abort_e%0d got %h want %h", i, obs, mk(int'(exp_q[i]), 1'b1, 1'b0));
            end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mq = 0;
        n_checks++;
        if (obs !== mk(0, 1'b0, 1'b0)) begin
            n_errors++;
            $display("FAIL abort_reset got %h want %h", obs, mk(0, 1'b0, 1'b0));
        end
        for (int i = 0; i < 4; i++) idle_check("abort_no_done");
    endtask

    task automatic test_back_to_back();
        do_load(8'h01);
        run_start(3, 3, "b2b_first");
        run_start(4, 2, "b2b_second");
        n_checks++;
        if (q !== 8'h02) begin
            n_errors++;
            $display("FAIL b2b_final got %h want 02", q);
        end
        idle_check("b2b_after");
    endtask

    task automatic test_random_starts();
        for (int i = 0; i < 30; i++) begin
            run_start($urandom_range(0, 7), $urandom_range(0, 15), "rand_start");
            if ($urandom_range(0, 2) == 0) idle_check("rand_gap");
        end
        idle_check("rand_end");
    endtask

    initial begin
        test_reset();
        test_single_ops();
        test_multi_step();
        test_edge_counts();
        test_abort();
        test_back_to_back();
        test_random_starts();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
